// File: rtl/ripple_count_capture.sv
// Brings a free-running asynchronous ripple-counter value into the clk domain:
// per-bit 2-FF synchronisers, a settle filter, and a valid/ready publish port carrying count, delta and wrap.
module ripple_count_capture #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_count,
    output logic [WIDTH-1:0] out_delta,
    output logic             out_wrap,
    output logic             backlog
);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SETTLE,
        S_EMIT
    } state_t;

    // Value of stable_q on the cycle that completes the required run of equal samples.
    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);

    state_t           state_q;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] last_pub_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] delta_q;
    logic [3:0]       stable_q;
    logic             valid_q;
    logic             wrap_q;
    logic             backlog_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_WAIT;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            last_pub_q <= '0;
            count_q    <= '0;
            delta_q    <= '0;
            stable_q   <= '0;
            valid_q    <= 1'b0;
            wrap_q     <= 1'b0;
            backlog_q  <= 1'b0;
        end else begin
            sync1_q <= cnt_in;
            sync2_q <= sync1_q;

            case (state_q)
                S_WAIT: begin
                    backlog_q <= 1'b0;
                    if (sync2_q != last_pub_q) begin
                        cand_q   <= sync2_q;
                        stable_q <= 4'd1;
                        state_q  <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    backlog_q <= 1'b0;
                    // Falling back to the last published value is a ripple glitch, not a count.
                    if (sync2_q == last_pub_q) begin
                        state_q <= S_WAIT;
                    end else if (sync2_q != cand_q) begin
                        cand_q   <= sync2_q;
                        stable_q <= 4'd1;
                    end else if (stable_q == STABLE_LAST) begin
                        count_q    <= cand_q;
                        delta_q    <= cand_q - last_pub_q;
                        wrap_q     <= (cand_q < last_pub_q);
                        last_pub_q <= cand_q;
                        valid_q    <= 1'b1;
                        state_q    <= S_EMIT;
                    end else begin
                        stable_q <= stable_q + 4'd1;
                    end
                end

                S_EMIT: begin
                    if (valid_q && out_ready) begin
                        valid_q   <= 1'b0;
                        backlog_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end else begin
                        backlog_q <= (sync2_q != count_q);
                    end
                end

                default: begin
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign out_count = count_q;
    assign out_delta = delta_q;
    assign out_wrap  = wrap_q;
    assign backlog   = backlog_q;

endmodule
